// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO with a valid/ready push port feeding a serialiser.
// Define UART_TX_PARITY_EN to compile in an even-parity bit (8E1 frames).
module uart_tx_buf #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_vld,
    input  logic [7:0]                    tx_data,
    output logic                          tx_rdy,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]    r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
    logic          w_par_nxt;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_nempty;
    logic          w_baud_end;
    logic [7:0]    w_head;
    logic [2:0]    w_state_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tx_nxt;
    logic          w_busy_nxt;

    // A push is refused whenever the stored count is full, even if a pop lands on the same edge.
    assign tx_rdy        = (r_cnt != CNT_FULL);
    assign w_push        = tx_vld && tx_rdy;
    assign w_fifo_nempty = (r_cnt != CNT_ZERO);
    assign w_baud_end    = (r_baud == BAUD_LAST);
    assign w_head        = r_mem[r_rptr];

    assign uart_tx  = r_tx;
    assign busy     = r_busy;
    assign fifo_cnt = r_cnt;

    // Next-state and next-line-level decode; uart_tx is registered from the level of the state being entered.
    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_baud_nxt  = w_baud_end ? BAUD_ZERO : r_baud + 1'b1;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = BAUD_ZERO;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_shift_nxt = w_head;
                    w_bit_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = even_parity(w_head);
`endif
                end else begin
                    w_tx_nxt   = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 1'b1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                // Popping on the last stop cycle makes back-to-back frames gapless.
                if (w_baud_end) begin
                    if (w_fifo_nempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                        w_tx_nxt    = 1'b0;
                        w_shift_nxt = w_head;
                        w_bit_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_par_nxt   = even_parity(w_head);
`endif
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_baud_nxt  = BAUD_ZERO;
            end
        endcase
    end

    // Serialiser and FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= BAUD_ZERO;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_cnt   <= CNT_ZERO;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Byte storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: accepted bytes are queued, a serial-line monitor decodes frames and compares.
module tb_uart_tx_buf;

    localparam int BIT_T = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BIT_T;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_cnt;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    bit         mon_skip = 1'b0;

    uart_tx_buf #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_vld   (tx_vld),
        .tx_data  (tx_data),
        .tx_rdy   (tx_rdy),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one byte and hold it until the DUT takes it; the byte is queued as expected line data.
    task automatic send(input logic [7:0] d, output int cnt_seen, output int acc_cyc);
        cnt_seen = -1;
        acc_cyc  = -1;
        tx_vld   = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_rdy) begin
                cnt_seen = int'(fifo_cnt);
                acc_cyc  = cyc;
                exp_q.push_back(d);
                @(posedge clk);
                #1;
                tx_vld = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tx_vld = 1'b0;
        total++;
        bad++;
        $display("FAIL send_timeout: byte 0x%0h never accepted, expected acceptance within 400 cycles", d);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && fifo_cnt == 3'd0 && exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: still busy=%0d queued=%0d, expected idle within 3000 cycles", name, busy, exp_q.size());
    endtask

    // Line monitor: finds a start bit, samples each bit mid-cell and checks against the scoreboard.
    initial begin : monitor
        logic [7:0] d;
        logic [7:0] e;
        logic       stp;
`ifdef UART_TX_PARITY_EN
        logic       p;
`endif
        forever begin
            @(negedge clk);
            if (!rst && uart_tx == 1'b0) begin
                starts.push_back(cyc);
                repeat (BIT_T / 2) @(negedge clk);
                chk("mon_start_bit", int'(uart_tx), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_T) @(negedge clk);
                    d[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (BIT_T) @(negedge clk);
                p = uart_tx;
`endif
                repeat (BIT_T) @(negedge clk);
                stp = uart_tx;
                if (mon_skip) begin
                    mon_skip = 1'b0;
                end else begin
                    chk("mon_stop_bit", int'(stp), 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mon_unexpected_frame: got byte 0x%0h, expected no frame", d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_rx_byte", int'(d), int'(e));
`ifdef UART_TX_PARITY_EN
                        chk("mon_parity", int'(p), int'(^e));
`endif
                    end
                end
            end
        end
    end

    initial begin : stim
        int cs;
        int ac;
        int ac0;
        int cs_a [3];
        int g1;
        int g2;
        int glitches;

        rst     = 1'b1;
        tx_vld  = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_uart_tx", int'(uart_tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fifo_cnt", int'(fifo_cnt), 0);
        chk("reset_tx_rdy", int'(tx_rdy), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte 0xA5, accepted at edge 0
        send(8'hA5, cs, ac);
        @(negedge clk);
        chk("t1_cnt_after_push", int'(fifo_cnt), 1);
        chk("t1_busy_before_pop", int'(busy), 0);
        chk("t1_line_idle", int'(uart_tx), 1);
        @(negedge clk);
        chk("t1_busy_rise", int'(busy), 1);
        chk("t1_start_low", int'(uart_tx), 0);
        chk("t1_cnt_after_pop", int'(fifo_cnt), 0);
        repeat (9) @(negedge clk);
        chk("t1_start_last_cycle", int'(uart_tx), 0);
        @(negedge clk);
        chk("t1_bit0", int'(uart_tx), 1);
        repeat (FRAME - 11) @(negedge clk);
        chk("t1_busy_last_stop", int'(busy), 1);
        @(negedge clk);
        chk("t1_busy_drop", int'(busy), 0);
        chk("t1_line_after", int'(uart_tx), 1);
        wait_idle("t1_drain");

        // Burst of three on consecutive edges
        starts.delete();
        send(8'h01, cs_a[0], ac);
        send(8'h02, cs_a[1], ac);
        send(8'h03, cs_a[2], ac);
        chk("burst_cnt_at_push0", cs_a[0], 0);
        chk("burst_cnt_at_push1", cs_a[1], 1);
        chk("burst_cnt_at_push2", cs_a[2], 1);
        @(negedge clk);
        chk("burst_cnt_after", int'(fifo_cnt), 2);
        wait_idle("burst_drain");
        chk("burst_frames", starts.size(), 3);
        g1 = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
        g2 = (starts.size() >= 3) ? starts[2] - starts[1] : -1;
        chk("burst_gap1", g1, FRAME);
        chk("burst_gap2", g2, FRAME);

        // Fill the FIFO during frame one; the sixth byte waits for the next pop
        send(8'h11, cs, ac0);
        send(8'h22, cs, ac);
        send(8'h33, cs, ac);
        send(8'h44, cs, ac);
        send(8'h55, cs, ac);
        @(negedge clk);
        chk("full_tx_rdy", int'(tx_rdy), 0);
        chk("full_cnt", int'(fifo_cnt), 4);
        @(posedge clk);
        #1;
        send(8'h66, cs, ac);
        chk("full_6th_accept_edge", ac - ac0, FRAME + 2);
        chk("full_6th_cnt_seen", cs, 3);
        wait_idle("full_drain");

        // Push lands on the STOP->START pop edge with two bytes waiting
        send(8'h5A, cs, ac0);
        send(8'hC3, cs, ac);
        send(8'h3C, cs, ac);
        repeat (FRAME - 2) @(posedge clk);
        #1;
        send(8'hE7, cs, ac);
        chk("sim_cnt_before", cs, 2);
        chk("sim_accept_edge", ac - ac0, FRAME + 1);
        @(negedge clk);
        chk("sim_cnt_after", int'(fifo_cnt), 2);
        chk("sim_restart_line", int'(uart_tx), 0);
        chk("sim_busy", int'(busy), 1);
        wait_idle("sim_drain");

        // Asynchronous reset during data bit 3 of 0xF0, with two more bytes queued
        send(8'hF0, cs, ac0);
        send(8'h0F, cs, ac);
        send(8'hAA, cs, ac);
        repeat (43) @(negedge clk);
        chk("rst_pre_line_bit3", int'(uart_tx), 0);
        chk("rst_pre_busy", int'(busy), 1);
        mon_skip = 1'b1;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("rst_async_uart_tx", int'(uart_tx), 1);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_async_tx_rdy", int'(tx_rdy), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        glitches = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) glitches++;
        end
        chk("rst_no_residual", glitches, 0);
        chk("rst_cnt_after", int'(fifo_cnt), 0);
        @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; frame length 11 bit times
        send(8'h07, cs, ac);
        repeat (96) @(negedge clk);
        chk("par_07_bit", int'(uart_tx), 1);
        repeat (FRAME - 95) @(negedge clk);
        chk("par_busy_last_stop", int'(busy), 1);
        @(negedge clk);
        chk("par_busy_drop", int'(busy), 0);
        wait_idle("par_07_drain");
        send(8'h03, cs, ac);
        repeat (96) @(negedge clk);
        chk("par_03_bit", int'(uart_tx), 0);
        wait_idle("par_03_drain");
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
